mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch port, load/store port and data_memory port of the
// shared single-port memory. slave = arbiter view, master = clients + memory.
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16
);
  // fetch port
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_done;
  logic [15:0]           i_rdata;
  // load/store port
  logic                  d_req;
  logic                  d_wr;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [15:0]           d_wdata;
  logic                  d_done;
  logic [15:0]           d_rdata;
  logic                  d_err;
  // data_memory side
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic                  mem_en;
  logic                  mem_wr;
  logic [15:0]           mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output i_done, i_rdata, d_done, d_rdata, d_err,
           mem_addr, mem_wdata, mem_en, mem_wr
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  i_done, i_rdata, d_done, d_rdata, d_err,
           mem_addr, mem_wdata, mem_en, mem_wr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port data_memory between the fetch (I)
// and load/store (D) ports. Each access holds the memory enabled for
// WAIT_CYCLES cycles, then pulses the owner's done for one cycle.
// Optional: define ARB_ROUND_ROBIN_EN to alternate grants under contention;
// otherwise D has fixed priority over I.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t                state, state_nx;
  logic [3:0]            cnt;
  logic                  own_d;    // 1 = D owns the current access
  logic                  wr_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           wdata_q;
  logic [15:0]           i_rdata_q;
  logic [15:0]           d_rdata_q;
  logic                  grant;
  logic                  grant_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic                  last_d;   // 1 = last grant went to D, 0 = I
`endif

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // next state, arbitration and memory/handshake strobes
  always_comb begin
    state_nx    = state;
    grant       = 1'b0;
    grant_d     = 1'b0;
    bus.mem_en  = 1'b0;
    bus.mem_wr  = 1'b0;
    bus.i_done  = 1'b0;
    bus.d_done  = 1'b0;
    bus.d_err   = 1'b0;
    case (state)
      IDLE: begin
        grant = bus.i_req | bus.d_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (bus.i_req && bus.d_req) grant_d = ~last_d;
        else                        grant_d = bus.d_req;
`else
        grant_d = bus.d_req;
`endif
        if (grant) begin
          // misaligned D access never touches memory
          if (grant_d && bus.d_addr[0]) state_nx = DONE;
          else                          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        bus.mem_en = 1'b1;
        bus.mem_wr = wr_q;
        if (cnt == 4'd0) state_nx = DONE;
      end
      DONE: begin
        bus.i_done = ~own_d;
        bus.d_done = own_d;
        bus.d_err  = own_d & err_q;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // request latch at grant, wait counter and read-data capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      own_d     <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (grant) begin
      own_d  <= grant_d;
      wr_q   <= grant_d & bus.d_wr;
      err_q  <= grant_d & bus.d_addr[0];
      addr_q <= grant_d ? bus.d_addr : bus.i_addr;
      if (grant_d) wdata_q <= bus.d_wdata;
      cnt    <= CNT_INIT;
    end else if (state == ACCESS) begin
      if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else if (!wr_q) begin
        if (own_d) d_rdata_q <= bus.mem_rdata;
        else       i_rdata_q <= bus.mem_rdata;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // remember who was granted last, error grants included
  always_ff @(posedge clk) begin
    if (!rst)       last_d <= 1'b0;
    else if (grant) last_d <= grant_d;
  end
`endif

  // memory address/data come only from the latched request
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter with WAIT_CYCLES=3
// against a behavioural word memory. Expected values are hand-computed.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [15:0] mem [0:32767];
  logic        pl_we = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  mem_port_arbiter_if #(.ADDR_WIDTH(16)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(16), .WAIT_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // memory model: combinational read, write on enabled store, or preload
  assign bus.mem_rdata = mem[bus.mem_addr[15:1]];
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_wr) mem[bus.mem_addr[15:1]] <= bus.mem_wdata;
    else if (pl_we)               mem[pl_addr[15:1]]     <= pl_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  // one request from IDLE; k=0 is the grant cycle. Entered and left at posedge+1.
  task automatic access(input bit is_d, input bit wr, input logic [15:0] a,
                        input logic [15:0] wd, output int done_k, output int en_cnt,
                        output bit err, output bit other);
    done_k = -1; en_cnt = 0; err = 1'b0; other = 1'b0;
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_wr = wr; bus.d_addr = a; bus.d_wdata = wd;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = a;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.mem_en) en_cnt++;
      if (is_d ? bus.i_done : bus.d_done) other = 1'b1;
      if (is_d ? bus.d_done : bus.i_done) begin
        done_k = k; err = bus.d_err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.d_req = 1'b0; bus.i_req = 1'b0;
  endtask

  initial begin
    int dk, en;
    bit er, oth;
    int n;
    int when_k [3];
    logic [1:0] kind [3];
    bit seen;

    rst = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    @(posedge clk); #1;
    preload(16'h0010, 16'hBEEF);
    preload(16'hFFFE, 16'hA5C3);

    // reset held with a pending fetch
    bus.i_req = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_i_done", bus.i_done, 0);
      chk("rst_i_rdata", bus.i_rdata, 0);
    end
    @(posedge clk); #1;
    bus.i_req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // fetch
    access(1'b0, 1'b0, 16'h0010, 16'h0, dk, en, er, oth);
    chk("fetch_done_k", dk, 4);
    chk("fetch_en_cycles", en, 3);
    chk("fetch_rdata", bus.i_rdata, 16'hBEEF);
    chk("fetch_no_d_done", oth, 0);

    // store then load
    access(1'b1, 1'b1, 16'h0100, 16'h1234, dk, en, er, oth);
    chk("store_done_k", dk, 4);
    chk("store_en_cycles", en, 3);
    chk("store_err", er, 0);
    chk("store_d_rdata_kept", bus.d_rdata, 0);
    access(1'b1, 1'b0, 16'h0100, 16'h0, dk, en, er, oth);
    chk("load_done_k", dk, 4);
    chk("load_rdata", bus.d_rdata, 16'h1234);
    chk("load_i_rdata_kept", bus.i_rdata, 16'hBEEF);

    // misaligned
    access(1'b1, 1'b0, 16'h0101, 16'h0, dk, en, er, oth);
    chk("mis_done_k", dk, 1);
    chk("mis_en_cycles", en, 0);
    chk("mis_err", er, 1);
    chk("mis_d_rdata_kept", bus.d_rdata, 16'h1234);

    // top of address space (also leaves last grant = I)
    access(1'b0, 1'b0, 16'hFFFE, 16'h0, dk, en, er, oth);
    chk("top_done_k", dk, 4);
    chk("top_rdata", bus.i_rdata, 16'hA5C3);

    // contention, both requests held
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0100;
    bus.i_req = 1'b1; bus.i_addr = 16'h0010;
    n = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if ((bus.i_done || bus.d_done) && n < 3) begin
        when_k[n] = k;
        kind[n]   = {bus.i_done, bus.d_done};
        n++;
      end
      @(posedge clk); #1;
    end
    bus.d_req = 1'b0; bus.i_req = 1'b0;
    chk("cont_count", n, 3);
    for (int e = 0; e < 3; e++) begin
      chk("cont_when", when_k[e], 4 + 5*e);
`ifdef ARB_ROUND_ROBIN_EN
      chk("cont_kind", kind[e], (e == 1) ? 2'b10 : 2'b01);
`else
      chk("cont_kind", kind[e], 2'b01);
`endif
    end
    @(posedge clk); #1;

    // reset during the 2nd ACCESS cycle of a store
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0200; bus.d_wdata = 16'h5555;
    @(negedge clk);            // k=0 grant
    @(posedge clk); #1;
    @(negedge clk);            // k=1
    chk("rsta_en_k1", bus.mem_en, 1);
    chk("rsta_wr_k1", bus.mem_wr, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);            // k=2, reset not yet sampled
    chk("rsta_en_k2", bus.mem_en, 1);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    @(negedge clk);
    chk("rsta_en_after", bus.mem_en, 0);
    chk("rsta_done_after", bus.d_done, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.d_done || bus.i_done || bus.mem_en) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("rsta_quiet", seen, 0);
    chk("rsta_d_rdata_clr", bus.d_rdata, 0);
    chk("rsta_i_rdata_clr", bus.i_rdata, 0);
    access(1'b0, 1'b0, 16'h0010, 16'h0, dk, en, er, oth);
    chk("rsta_fetch_done_k", dk, 4);
    chk("rsta_fetch_rdata", bus.i_rdata, 16'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
